// File: rtl/vga_pkg.sv
// Shared types and default geometry for the VGA framebuffer write path.
// Optional build macro: VGA_FB_VBLANK_GATE_EN (see vga_fb_write_arbiter).
package vga_pkg;

    localparam int ADDR_BITS  = 11;
    localparam int COLOR_BITS = 2;
    localparam int HD         = 1280;
    localparam int VD         = 1024;

    typedef enum logic [1:0] {
        BLACK = 2'd0,
        WHITE = 2'd1,
        BLUE  = 2'd2,
        GREEN = 2'd3
    } color_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    typedef struct packed {
        logic [ADDR_BITS-1:0] x0;
        logic [ADDR_BITS-1:0] y0;
        logic [ADDR_BITS-1:0] x1;
        logic [ADDR_BITS-1:0] y1;
    } rect_cmd_t;

endpackage

// File: rtl/vga_rect_walker.sv
// Rectangle cursor: clamps the far corner to the screen and walks
// row-major from (x0,y0), one pixel per step.
module vga_rect_walker #(
    parameter int AW = 11,
    parameter int HD = 1280,
    parameter int VD = 1024
) (
    input  logic          clk,
    input  logic          arstn,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] x0,
    input  logic [AW-1:0] y0,
    input  logic [AW-1:0] x1,
    input  logic [AW-1:0] y1,
    output logic [AW-1:0] x,
    output logic [AW-1:0] y,
    output logic          last,
    output logic          empty
);

    localparam logic [AW-1:0] XMAX = AW'(HD - 1);
    localparam logic [AW-1:0] YMAX = AW'(VD - 1);

    logic [AW-1:0] x1c, y1c;
    logic [AW-1:0] x0_q, x1_q, y1_q;

    assign x1c   = (x1 > XMAX) ? XMAX : x1;
    assign y1c   = (y1 > YMAX) ? YMAX : y1;
    assign empty = (x0 > x1c) || (y0 > y1c);
    assign last  = (x == x1_q) && (y == y1_q);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            x0_q <= '0;
            x1_q <= '0;
            y1_q <= '0;
            x    <= '0;
            y    <= '0;
        end else if (load) begin
            x0_q <= x0;
            x1_q <= x1c;
            y1_q <= y1c;
            x    <= x0;
            y    <= y0;
        end else if (step) begin
            if (x == x1_q) begin
                x <= x0_q;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_fb_write_arbiter.sv
// Round-robin sharing of the framebuffer write port between host pixels
// and the rect-fill engine. VGA_FB_VBLANK_GATE_EN: grant only in vblank.
module vga_fb_write_arbiter #(
    parameter int ADDR_BITS  = vga_pkg::ADDR_BITS,
    parameter int COLOR_BITS = vga_pkg::COLOR_BITS,
    parameter int HD         = vga_pkg::HD,
    parameter int VD         = vga_pkg::VD
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  pix_valid_i,
    output logic                  pix_ready_o,
    input  logic [ADDR_BITS-1:0]  pix_x_i,
    input  logic [ADDR_BITS-1:0]  pix_y_i,
    input  logic [COLOR_BITS-1:0] pix_color_i,
    input  logic                  rect_valid_i,
    output logic                  rect_ready_o,
    input  logic [ADDR_BITS-1:0]  rect_x0_i,
    input  logic [ADDR_BITS-1:0]  rect_y0_i,
    input  logic [ADDR_BITS-1:0]  rect_x1_i,
    input  logic [ADDR_BITS-1:0]  rect_y1_i,
    input  logic [COLOR_BITS-1:0] rect_color_i,
    input  logic                  vblank_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fb_we_o,
    output logic [ADDR_BITS-1:0]  fb_addr_x_o,
    output logic [ADDR_BITS-1:0]  fb_addr_y_o,
    output logic [COLOR_BITS-1:0] fb_color_o
);

    import vga_pkg::*;

    localparam logic [ADDR_BITS-1:0] XLIM = ADDR_BITS'(HD);
    localparam logic [ADDR_BITS-1:0] YLIM = ADDR_BITS'(VD);

    fill_state_t           state;
    rect_cmd_t             cmd;
    logic [COLOR_BITS-1:0] fill_color;
    logic [ADDR_BITS-1:0]  cur_x, cur_y;
    logic gate, fill_req, contested, grant_pix, grant_fill;
    logic prio_fill, accept, last, empty, pix_in_range;

`ifdef VGA_FB_VBLANK_GATE_EN
    assign gate = vblank_i;
`else
    logic unused_vblank;
    assign unused_vblank = vblank_i;
    assign gate          = 1'b1;
`endif

    assign cmd = '{x0: rect_x0_i, y0: rect_y0_i,
                   x1: rect_x1_i, y1: rect_y1_i};

    assign fill_req     = (state == FILL);
    assign contested    = pix_valid_i & fill_req;
    // prio_fill set means the pixel port won the last contested cycle
    assign grant_pix    = gate & pix_valid_i & (~fill_req | ~prio_fill);
    assign grant_fill   = gate & fill_req & (~pix_valid_i | prio_fill);
    assign pix_ready_o  = grant_pix;
    assign accept       = rect_ready_o & rect_valid_i;
    assign pix_in_range = (pix_x_i < XLIM) && (pix_y_i < YLIM);

    vga_rect_walker #(
        .AW (ADDR_BITS),
        .HD (HD),
        .VD (VD)
    ) u_walker (
        .clk   (clk),
        .arstn (arstn),
        .load  (accept),
        .step  (grant_fill),
        .x0    (cmd.x0),
        .y0    (cmd.y0),
        .x1    (cmd.x1),
        .y1    (cmd.y1),
        .x     (cur_x),
        .y     (cur_y),
        .last  (last),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state        <= IDLE;
            rect_ready_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            prio_fill    <= 1'b0;
            fill_color   <= '0;
        end else begin
            if (gate && contested)
                prio_fill <= grant_pix;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        fill_color   <= rect_color_i;
                        rect_ready_o <= 1'b0;
                        if (empty) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state  <= FILL;
                            busy_o <= 1'b1;
                        end
                    end else begin
                        rect_ready_o <= 1'b1;
                    end
                end
                FILL: begin
                    if (grant_fill && last) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    done_o       <= 1'b0;
                    rect_ready_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            fb_we_o     <= 1'b0;
            fb_addr_x_o <= '0;
            fb_addr_y_o <= '0;
            fb_color_o  <= '0;
        end else begin
            fb_we_o <= grant_fill | (grant_pix & pix_in_range);
            if (grant_fill) begin
                fb_addr_x_o <= cur_x;
                fb_addr_y_o <= cur_y;
                fb_color_o  <= fill_color;
            end else if (grant_pix && pix_in_range) begin
                fb_addr_x_o <= pix_x_i;
                fb_addr_y_o <= pix_y_i;
                fb_color_o  <= pix_color_i;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_write_arbiter.sv
// Scoreboard bench for vga_fb_write_arbiter: expected writes are queued
// at stimulus time and popped by a monitor whenever fb_we_o is high.
module tb_vga_fb_write_arbiter;

    localparam int AW = 11;
    localparam int CW = 2;

    typedef logic [2*AW+CW-1:0] wr_t;

    logic          clk = 1'b0;
    logic          arstn = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [AW-1:0] pix_x = '0, pix_y = '0;
    logic [CW-1:0] pix_color = '0;
    logic          rect_valid = 1'b0;
    logic          rect_ready;
    logic [AW-1:0] rx0 = '0, ry0 = '0, rx1 = '0, ry1 = '0;
    logic [CW-1:0] rcolor = '0;
    logic          vblank = 1'b1;
    logic          busy, done, fb_we;
    logic [AW-1:0] fb_x, fb_y;
    logic [CW-1:0] fb_color;

    wr_t q[$];
    int  n_vec = 0, n_err = 0, n_done = 0, n_wr = 0;
    int  w0, d0, k;

    always #5 clk = ~clk;

    vga_fb_write_arbiter dut (
        .clk          (clk),
        .arstn        (arstn),
        .pix_valid_i  (pix_valid),
        .pix_ready_o  (pix_ready),
        .pix_x_i      (pix_x),
        .pix_y_i      (pix_y),
        .pix_color_i  (pix_color),
        .rect_valid_i (rect_valid),
        .rect_ready_o (rect_ready),
        .rect_x0_i    (rx0),
        .rect_y0_i    (ry0),
        .rect_x1_i    (rx1),
        .rect_y1_i    (ry1),
        .rect_color_i (rcolor),
        .vblank_i     (vblank),
        .busy_o       (busy),
        .done_o       (done),
        .fb_we_o      (fb_we),
        .fb_addr_x_o  (fb_x),
        .fb_addr_y_o  (fb_y),
        .fb_color_o   (fb_color)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic wr_t mk(input int x, input int y, input int c);
        return {AW'(x), AW'(y), CW'(c)};
    endfunction

    task automatic push(input int x, input int y, input int c);
        q.push_back(mk(x, y, c));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rect(input int x0, input int y0, input int x1,
                        input int y1, input int c);
        rect_valid = 1'b1;
        rx0 = AW'(x0); ry0 = AW'(y0);
        rx1 = AW'(x1); ry1 = AW'(y1);
        rcolor = CW'(c);
    endtask

    task automatic wait_done(input string tag, input logic we_exp);
        bit seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd1);
        if (seen) chk({tag, "_we"}, {31'd0, fb_we}, {31'd0, we_exp});
    endtask

    always @(negedge clk) begin
        if (fb_we) begin
            n_wr++;
            if (q.size() == 0) chk("unexp_wr", {31'd0, fb_we}, 32'd0);
            else chk("wr", {8'd0, fb_x, fb_y, fb_color}, {8'd0, q.pop_front()});
        end
        if (done) n_done++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_we", {31'd0, fb_we}, 0);
        chk("rst_x", {21'd0, fb_x}, 0);
        chk("rst_y", {21'd0, fb_y}, 0);
        chk("rst_col", {30'd0, fb_color}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_rdy", {31'd0, rect_ready}, 0);
        @(posedge clk); #1 arstn = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("rdy_idle", {31'd0, rect_ready}, 1);

        // single host pixel
        tick();
        pix_valid = 1'b1; pix_x = 5; pix_y = 7; pix_color = 2;
        push(5, 7, 2);
        @(negedge clk); chk("pix_rdy", {31'd0, pix_ready}, 1);
        tick(); pix_valid = 1'b0;
        @(negedge clk); chk("pix_we", {31'd0, fb_we}, 1);
        tick(); tick();

        // 3x2 rectangle, inputs scrambled after acceptance
        tick();
        rect(2, 3, 4, 4, 1);
        for (int yy = 3; yy <= 4; yy++)
            for (int xx = 2; xx <= 4; xx++) push(xx, yy, 1);
        @(negedge clk); chk("rect_acc", {31'd0, rect_ready}, 1);
        tick();
        rect(100, 100, 200, 200, 3); rect_valid = 1'b0;
        @(negedge clk);
        chk("rect_busy", {31'd0, busy}, 1);
        chk("rect_rdy_lo", {31'd0, rect_ready}, 0);
        wait_done("rect_done", 1'b1);
        @(negedge clk); chk("done_1cyc", {31'd0, done}, 0);
        chk("rect_q", q.size(), 0);

        // contention: rect plus continuous pixel traffic
        tick();
        d0 = n_done;
        rect(0, 0, 3, 0, 3);
        pix_valid = 1'b1; pix_x = 100; pix_y = 200; pix_color = 2;
        push(100, 200, 2); push(101, 200, 2);
        for (int i = 0; i < 4; i++) begin
            push(i, 0, 3);
            push(102 + i, 200, 2);
        end
        push(106, 200, 2);
        k = 0;
        for (int c = 0; c < 30 && k < 7; c++) begin
            @(negedge clk);
            if (c == 0) chk("cont_acc", {31'd0, rect_ready}, 1);
            if (pix_ready) k++;
            tick();
            rect_valid = 1'b0;
            pix_x = AW'(100 + k);
        end
        pix_valid = 1'b0;
        chk("cont_pix_n", k, 7);
        tick(); tick();
        chk("cont_done", n_done - d0, 1);
        chk("cont_q", q.size(), 0);

        // far corner clamped to the screen edge
        tick();
        rect(1278, 1022, 2000, 2000, 2);
        push(1278, 1022, 2); push(1279, 1022, 2);
        push(1278, 1023, 2); push(1279, 1023, 2);
        tick(); rect_valid = 1'b0;
        wait_done("clamp_done", 1'b1);
        tick(); tick();
        chk("clamp_q", q.size(), 0);

        // inverted rectangle: done without writes
        w0 = n_wr;
        tick();
        rect(10, 0, 5, 0, 1);
        @(negedge clk); chk("empty_acc", {31'd0, rect_ready}, 1);
        tick(); rect_valid = 1'b0;
        wait_done("empty_done", 1'b0);
        tick(); tick();
        chk("empty_nowr", n_wr - w0, 0);

        // out-of-range pixels accepted and dropped
        w0 = n_wr;
        tick();
        pix_valid = 1'b1; pix_x = 1280; pix_y = 0; pix_color = 1;
        @(negedge clk); chk("oor_rdy", {31'd0, pix_ready}, 1);
        tick(); pix_x = 0; pix_y = 1024;
        @(negedge clk); chk("oor_rdy2", {31'd0, pix_ready}, 1);
        tick(); pix_valid = 1'b0;
        @(negedge clk); chk("oor_we", {31'd0, fb_we}, 0);
        tick();
        chk("oor_nowr", n_wr - w0, 0);

        // reset in the middle of a fill
        tick();
        rect(0, 0, 9, 9, 1);
        push(0, 0, 1); push(1, 0, 1); push(2, 0, 1);
        tick(); rect_valid = 1'b0;
        tick(); tick(); tick();
        @(negedge clk);
        d0 = n_done;
        #1 arstn = 1'b0;
        #1;
        chk("mid_we", {31'd0, fb_we}, 0);
        chk("mid_busy", {31'd0, busy}, 0);
        chk("mid_rdy", {31'd0, rect_ready}, 0);
        chk("mid_x", {21'd0, fb_x}, 0);
        repeat (3) @(negedge clk);
        chk("mid_nodone", n_done - d0, 0);
        chk("mid_q", q.size(), 0);
        @(posedge clk); #1 arstn = 1'b1;
        tick(); tick();
        rect(7, 7, 7, 7, 3);
        push(7, 7, 3);
        @(negedge clk); chk("post_acc", {31'd0, rect_ready}, 1);
        tick(); rect_valid = 1'b0;
        wait_done("post_done", 1'b1);

`ifdef VGA_FB_VBLANK_GATE_EN
        // grants stall outside vertical blanking
        tick();
        vblank = 1'b0;
        pix_valid = 1'b1; pix_x = 9; pix_y = 9; pix_color = 3;
        push(9, 9, 3);
        @(negedge clk); chk("vb_stall", {31'd0, pix_ready}, 0);
        tick();
        @(negedge clk);
        chk("vb_stall2", {31'd0, pix_ready}, 0);
        chk("vb_nowe", {31'd0, fb_we}, 0);
        tick(); vblank = 1'b1;
        @(negedge clk); chk("vb_go", {31'd0, pix_ready}, 1);
        tick(); pix_valid = 1'b0;
        @(negedge clk); chk("vb_we", {31'd0, fb_we}, 1);
`endif

        tick(); tick(); tick();
        chk("q_end", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
